// File: rtl/boxhead_pkg.sv
// Shared constants and types for the boxhead player-health slice.
package boxhead_pkg;

  localparam int unsigned ENEMY_NUM  = 4;
  localparam int unsigned FULL_BLOOD = 100;
  localparam int unsigned BAR_HEIGHT = 4;
  localparam int unsigned BLOOD_W    = 10;
  localparam int unsigned DMG_W      = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } health_state_t;

endpackage

// File: rtl/health_bar_sprite.sv
// Registered health-bar rectangle and fill compare; one Clk behind PixelX/PixelY,
// matching the synchronous sprite ROMs.
module health_bar_sprite
  import boxhead_pkg::*;
#(
  parameter int unsigned BAR_X   = 8,
  parameter int unsigned BAR_Y   = 4,
  parameter int unsigned BAR_LEN = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [8:0]         pixel_x,
  input  logic [8:0]         pixel_y,
  input  logic [BLOOD_W-1:0] blood,
  output logic               is_obj,
  output logic               bar_filled
);

  localparam logic [9:0] X_LO = 10'(BAR_X);
  localparam logic [9:0] X_HI = 10'(BAR_X + BAR_LEN);
  localparam logic [9:0] Y_LO = 10'(BAR_Y);
  localparam logic [9:0] Y_HI = 10'(BAR_Y + BAR_HEIGHT);

  logic       is_obj_q, is_obj_d;
  logic       bar_filled_q, bar_filled_d;
  logic [9:0] px, py, x_off;
  logic       in_x, in_y;

  always_comb begin
    px           = 10'(pixel_x);
    py           = 10'(pixel_y);
    x_off        = px - X_LO;
    in_x         = (px >= X_LO) && (px < X_HI);
    in_y         = (py >= Y_LO) && (py < Y_HI);
    is_obj_d     = en && in_x && in_y;
    bar_filled_d = is_obj_d && (x_off < blood);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_obj_q     <= 1'b0;
      bar_filled_q <= 1'b0;
    end else begin
      is_obj_q     <= is_obj_d;
      bar_filled_q <= bar_filled_d;
    end
  end

  assign is_obj     = is_obj_q;
  assign bar_filled = bar_filled_q;

endmodule

// File: rtl/player_health_ctrl.sv
// Player health FSM with hit damage, invulnerability frames and health-bar sprite.
// Optional build macro HEALTH_REGEN_EN adds slow regeneration while ALIVE.
module player_health_ctrl #(
  parameter int unsigned ENEMY_NUM     = boxhead_pkg::ENEMY_NUM,
  parameter int unsigned FULL_BLOOD    = boxhead_pkg::FULL_BLOOD,
  parameter int unsigned HIT_DAMAGE    = 10,
  parameter int unsigned IFRAME_FRAMES = 30,
  parameter int unsigned REGEN_FRAMES  = 120,
  parameter int unsigned BAR_X         = 8,
  parameter int unsigned BAR_Y         = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 game_frame_clk_rising_edge,
  input  logic                 Game_Start_On,
  input  logic [ENEMY_NUM-1:0] Enemy_Hit,
  input  logic [8:0]           PixelX,
  input  logic [8:0]           PixelY,
  output logic [9:0]           Player_Blood,
  output logic                 Game_Over_On,
  output logic                 Hit_Flash,
  output logic                 is_obj,
  output logic                 Bar_Filled
);

  import boxhead_pkg::*;

  // One counter width covers both the iframe and regen counts.
  localparam int unsigned CNT_MAX = (IFRAME_FRAMES > REGEN_FRAMES) ? IFRAME_FRAMES : REGEN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [BLOOD_W-1:0] BLOOD_FULL = BLOOD_W'(FULL_BLOOD);

  health_state_t      state_q, state_d;
  logic [BLOOD_W-1:0] blood_q, blood_d;
  logic [CNT_W-1:0]   iframe_q, iframe_d;
  logic               game_over_q, game_over_d;
  logic               hit_flash_q, hit_flash_d;
  logic               start_q;
  logic [DMG_W-1:0]   hit_cnt, dmg;
  logic               hit_any, start_rise, tick;
`ifdef HEALTH_REGEN_EN
  logic [CNT_W-1:0]   regen_q, regen_d;
`endif

  // Stacked damage for every enemy hit landing this cycle.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < int'(ENEMY_NUM); i++) begin
      hit_cnt = hit_cnt + DMG_W'(Enemy_Hit[i]);
    end
    dmg        = hit_cnt * DMG_W'(HIT_DAMAGE);
    hit_any    = |Enemy_Hit;
    start_rise = Game_Start_On && !start_q;
    tick       = game_frame_clk_rising_edge;
  end

  always_comb begin
    state_d  = state_q;
    blood_d  = blood_q;
    iframe_d = iframe_q;
`ifdef HEALTH_REGEN_EN
    regen_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        blood_d  = BLOOD_FULL;
        iframe_d = '0;
        if (!Game_Start_On) state_d = ALIVE;
      end
      ALIVE: begin
        if (start_rise) begin
          state_d = IDLE;
          blood_d = BLOOD_FULL;
        end else if (hit_any) begin
          if (DMG_W'(blood_q) > dmg) begin
            blood_d  = blood_q - BLOOD_W'(dmg);
            state_d  = INVULN;
            iframe_d = CNT_W'(IFRAME_FRAMES);
          end else begin
            blood_d = '0;
            state_d = DEAD;
          end
        end else begin
`ifdef HEALTH_REGEN_EN
          regen_d = regen_q;
          if (tick) begin
            if (regen_q + CNT_W'(1) >= CNT_W'(REGEN_FRAMES)) begin
              regen_d = '0;
              if (blood_q < BLOOD_FULL) blood_d = blood_q + BLOOD_W'(1);
            end else begin
              regen_d = regen_q + CNT_W'(1);
            end
          end
`endif
        end
      end
      INVULN: begin
        if (start_rise) begin
          state_d  = IDLE;
          blood_d  = BLOOD_FULL;
          iframe_d = '0;
        end else if (tick) begin
          if (iframe_q <= CNT_W'(1)) begin
            iframe_d = '0;
            state_d  = ALIVE;
          end else begin
            iframe_d = iframe_q - CNT_W'(1);
          end
        end
      end
      DEAD: begin
        blood_d = '0;
      end
      default: state_d = IDLE;
    endcase
    game_over_d = (state_d == DEAD);
    hit_flash_d = (state_d == INVULN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      blood_q     <= BLOOD_FULL;
      iframe_q    <= '0;
      game_over_q <= 1'b0;
      hit_flash_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blood_q     <= blood_d;
      iframe_q    <= iframe_d;
      game_over_q <= game_over_d;
      hit_flash_q <= hit_flash_d;
      start_q     <= Game_Start_On;
    end
  end

`ifdef HEALTH_REGEN_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) regen_q <= '0;
    else          regen_q <= regen_d;
  end
`endif

  health_bar_sprite #(
    .BAR_X   (BAR_X),
    .BAR_Y   (BAR_Y),
    .BAR_LEN (FULL_BLOOD)
  ) u_bar (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (state_q != IDLE),
    .pixel_x    (PixelX),
    .pixel_y    (PixelY),
    .blood      (blood_q),
    .is_obj     (is_obj),
    .bar_filled (Bar_Filled)
  );

  assign Player_Blood = blood_q;
  assign Game_Over_On = game_over_q;
  assign Hit_Flash    = hit_flash_q;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Directed self-checking bench for player_health_ctrl (default build).
module tb_player_health_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       game_frame_clk_rising_edge;
  logic       Game_Start_On;
  logic [3:0] Enemy_Hit;
  logic [8:0] PixelX, PixelY;
  logic [9:0] Player_Blood;
  logic       Game_Over_On, Hit_Flash, is_obj, Bar_Filled;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  player_health_ctrl dut (
    .Clk                        (Clk),
    .Reset_n                    (Reset_n),
    .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
    .Game_Start_On              (Game_Start_On),
    .Enemy_Hit                  (Enemy_Hit),
    .PixelX                     (PixelX),
    .PixelY                     (PixelY),
    .Player_Blood               (Player_Blood),
    .Game_Over_On               (Game_Over_On),
    .Hit_Flash                  (Hit_Flash),
    .is_obj                     (is_obj),
    .Bar_Filled                 (Bar_Filled)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] h);
    game_frame_clk_rising_edge = 1'b1;
    Enemy_Hit = h;
    step();
    game_frame_clk_rising_edge = 1'b0;
    Enemy_Hit = '0;
  endtask

  task automatic hit(input logic [3:0] h);
    Enemy_Hit = h;
    step();
    Enemy_Hit = '0;
  endtask

  initial begin
    int cnt_obj, cnt_fill;
    Reset_n = 1'b0;
    Game_Start_On = 1'b1;
    Enemy_Hit = '0;
    game_frame_clk_rising_edge = 1'b0;
    PixelX = 9'd20;
    PixelY = 9'd5;
    #12;
    chk("rst_blood", 32'(Player_Blood), 100);
    chk("rst_over", 32'(Game_Over_On), 0);
    chk("rst_flash", 32'(Hit_Flash), 0);
    chk("rst_obj", 32'(is_obj), 0);
    chk("rst_fill", 32'(Bar_Filled), 0);

    // IDLE ignores hits and blanks the bar
    Reset_n = 1'b1;
    hit(4'b0001);
    chk("idle_hit_blood", 32'(Player_Blood), 100);
    chk("idle_hit_flash", 32'(Hit_Flash), 0);
    chk("idle_obj_off", 32'(is_obj), 0);
    Game_Start_On = 1'b0;
    step();
    step();
    chk("alive_obj", 32'(is_obj), 1);
    chk("alive_fill", 32'(Bar_Filled), 1);

    // single hit and iframe window
    hit(4'b0001);
    chk("hit1_blood", 32'(Player_Blood), 90);
    chk("hit1_flash", 32'(Hit_Flash), 1);
    chk("hit1_over", 32'(Game_Over_On), 0);
    repeat (29) frame(4'b1111);
    chk("ifr29_blood", 32'(Player_Blood), 90);
    chk("ifr29_flash", 32'(Hit_Flash), 1);
    frame(4'b0001);
    chk("ifr30_blood", 32'(Player_Blood), 90);
    chk("ifr30_flash", 32'(Hit_Flash), 0);

    // start screen rising returns to IDLE with reload
    Game_Start_On = 1'b1;
    step();
    chk("restart_blood", 32'(Player_Blood), 100);
    chk("restart_flash", 32'(Hit_Flash), 0);
    Game_Start_On = 1'b0;
    step();

    // stacked hits
    hit(4'b1011);
    chk("stack_blood", 32'(Player_Blood), 70);
    chk("stack_flash", 32'(Hit_Flash), 1);
    repeat (29) frame(4'b0100);
    chk("stack_ifr_blood", 32'(Player_Blood), 70);
    chk("stack_ifr_flash", 32'(Hit_Flash), 1);
    frame(4'b1000);
    chk("stack_end_blood", 32'(Player_Blood), 70);
    chk("stack_end_flash", 32'(Hit_Flash), 0);
    hit(4'b0111);
    chk("to40_blood", 32'(Player_Blood), 40);

    // bar sweep at blood 40
    cnt_obj = 0;
    cnt_fill = 0;
    for (int x = 0; x < 128; x++) begin
      PixelX = 9'(x);
      PixelY = 9'd5;
      step();
      chk("sweep_obj", 32'(is_obj), 32'((x >= 8 && x < 108) ? 1 : 0));
      chk("sweep_fill", 32'(Bar_Filled), 32'((x >= 8 && x < 48) ? 1 : 0));
      cnt_obj += int'(is_obj);
      cnt_fill += int'(Bar_Filled);
    end
    chk("sweep_obj_cnt", 32'(cnt_obj), 100);
    chk("sweep_fill_cnt", 32'(cnt_fill), 40);
    PixelX = 9'd20;
    PixelY = 9'd3;
    step();
    chk("y_above", 32'(is_obj), 0);
    PixelY = 9'd7;
    step();
    chk("y_last", 32'(is_obj), 1);
    PixelY = 9'd8;
    step();
    chk("y_below", 32'(is_obj), 0);

    // drive to death with saturation
    repeat (30) frame(4'b0000);
    chk("pre20_flash", 32'(Hit_Flash), 0);
    hit(4'b0011);
    chk("to20_blood", 32'(Player_Blood), 20);
    repeat (30) frame(4'b0000);
    hit(4'b1111);
    chk("sat_blood", 32'(Player_Blood), 0);
    chk("sat_over", 32'(Game_Over_On), 1);
    chk("sat_flash", 32'(Hit_Flash), 0);
    hit(4'b1111);
    Game_Start_On = 1'b1;
    step();
    Game_Start_On = 1'b0;
    step();
    frame(4'b0001);
    chk("dead_blood", 32'(Player_Blood), 0);
    chk("dead_over", 32'(Game_Over_On), 1);

    // asynchronous reset out of DEAD
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_blood", 32'(Player_Blood), 100);
    chk("arst_over", 32'(Game_Over_On), 0);
    @(negedge Clk) Reset_n = 1'b1;
    step();

    // ten separated single hits
    for (int i = 1; i <= 10; i++) begin
      hit(4'b0001);
      chk("ten_blood", 32'(Player_Blood), 32'(100 - 10 * i));
      if (i < 10) repeat (30) frame(4'b0000);
    end
    chk("ten_over", 32'(Game_Over_On), 1);
    chk("ten_flash", 32'(Hit_Flash), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
